// File: rtl/cam_pkg.sv
// Shared types for the camera metering path.
//   PIXEL_W     : default RAW pixel width
//   cam_stats_t : per-frame exposure statistics record
//   cam_state_t : metering FSM states
package cam_pkg;

  localparam int PIXEL_W = 10;

  typedef struct packed {
    logic [31:0]        sum;
    logic [23:0]        pixel_count;
    logic [PIXEL_W-1:0] max_pixel;
    logic [23:0]        sat_count;
    logic               short_frame;
  } cam_stats_t;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_FRAME,
    ACTIVE,
    LATCH
  } cam_state_t;

endpackage

// File: rtl/pixel_window_counter.sv
// Pixel position tracker and window qualifier.
// Inputs are the already-registered fv/lv. It keeps one-cycle-delayed copies
// for edge detection and tracks the current column x and line y.
//   clk, reset_n    : pixel clock, async active-low reset
//   fv, lv          : registered frame/line valid
//   x, y            : position of the pixel in this cycle (reads 0,0 on fv rise)
//   in_window       : current position lies inside the programmed rectangle
//   fv_rise/fv_fall : frame valid edges
//   lv_fall         : end of a line inside a frame (also when fv drops with lv)
module pixel_window_counter #(
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0,
  parameter int X        = 1288,
  parameter int Y        = 768
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fv,
  input  logic        lv,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        in_window,
  output logic        fv_rise,
  output logic        fv_fall,
  output logic        lv_fall
);

  localparam logic [31:0] X_LO = 32'(X_OFFSET);
  localparam logic [31:0] X_HI = 32'(X_OFFSET + X);
  localparam logic [31:0] Y_LO = 32'(Y_OFFSET);
  localparam logic [31:0] Y_HI = 32'(Y_OFFSET + Y);

  logic        fv_d;
  logic        line;
  logic        line_d;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [31:0] xw;
  logic [31:0] yw;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // lv only has meaning while fv is high
  assign line    = fv & lv;
  assign fv_rise = fv & ~fv_d;
  assign fv_fall = ~fv & fv_d;
  assign lv_fall = line_d & ~line;

  // The rising-edge cycle already carries pixel (0,0)
  assign x  = fv_rise ? 16'd0 : x_q;
  assign y  = fv_rise ? 16'd0 : y_q;
  assign xw = 32'(x);
  assign yw = 32'(y);

  assign in_window = (xw >= X_LO) && (xw < X_HI) && (yw >= Y_LO) && (yw < Y_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // fv_d held high so a frame still running at reset release shows no rise
      fv_d   <= 1'b1;
      line_d <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      fv_d   <= fv;
      line_d <= line;
      if (fv_rise) begin
        x_q <= line ? 16'd1 : 16'd0;
        y_q <= '0;
      end else if (lv_fall) begin
        x_q <= '0;
        y_q <= sat_inc16(y_q);
      end else if (line) begin
        x_q <= sat_inc16(x_q);
      end
    end
  end

endmodule

// File: rtl/cam_metering.sv
// Per-frame exposure statistics over a programmable window.
//   clk, reset_n   : pixel clock, async active-low reset
//   pixel_data     : pixel value, qualified by fv & lv
//   fv, lv         : frame / line valid
//   sum            : latched saturating window pixel sum
//   pixel_count    : latched number of window pixels
//   max_pixel      : latched largest window pixel
//   sat_count      : latched window pixels >= SAT_THRESH
//   frame_count    : frames measured, wraps 255 -> 0
//   short_frame    : last frame ended before the window's last line completed
//   result_valid   : one-cycle pulse when the latched outputs update
module cam_metering #(
  parameter int PIXEL_W    = cam_pkg::PIXEL_W,
  parameter int X_OFFSET   = 0,
  parameter int Y_OFFSET   = 0,
  parameter int X          = 1288,
  parameter int Y          = 768,
  parameter int SAT_THRESH = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               fv,
  input  logic               lv,
  output logic [31:0]        sum,
  output logic [23:0]        pixel_count,
  output logic [PIXEL_W-1:0] max_pixel,
  output logic [23:0]        sat_count,
  output logic [7:0]         frame_count,
  output logic               short_frame,
  output logic               result_valid
);
  import cam_pkg::*;

  localparam logic [31:0] SAT_LVL   = 32'(SAT_THRESH);
  localparam logic [31:0] LINES_REQ = 32'(Y_OFFSET + Y);

  logic               fv_p1;
  logic               lv_p1;
  logic [PIXEL_W-1:0] pixel_p1;
  logic [31:0]        pix_ext;
  logic [15:0]        x;
  logic [15:0]        y;
  logic               in_window;
  logic               fv_rise;
  logic               fv_fall;
  logic               lv_fall;
  cam_state_t         state;
  cam_state_t         state_nxt;
  logic               clear_acc;
  logic               track;
  logic               latch;
  logic               accumulate;
  cam_stats_t         acc;
  cam_stats_t         acc_base;
  cam_stats_t         res;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [PIXEL_W-1:0] p);
    logic [32:0] s;
    s = {1'b0, a} + 33'(p);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [23:0] sat_inc24(input logic [23:0] a, input logic inc);
    return (inc && (a != 24'hFF_FFFF)) ? a + 24'd1 : a;
  endfunction

  // ---- stage p1: input registration ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // High so that a frame in progress at reset release is not seen as new
      fv_p1 <= 1'b1;
      lv_p1 <= 1'b0;
    end else begin
      fv_p1 <= fv;
      lv_p1 <= lv;
    end
  end

  always_ff @(posedge clk) begin
    pixel_p1 <= pixel_data;
  end

  assign pix_ext = 32'(pixel_p1);

  pixel_window_counter #(
    .X_OFFSET (X_OFFSET),
    .Y_OFFSET (Y_OFFSET),
    .X        (X),
    .Y        (Y)
  ) u_window (
    .clk       (clk),
    .reset_n   (reset_n),
    .fv        (fv_p1),
    .lv        (lv_p1),
    .x         (x),
    .y         (y),
    .in_window (in_window),
    .fv_rise   (fv_rise),
    .fv_fall   (fv_fall),
    .lv_fall   (lv_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_LOW;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_acc = 1'b0;
    track     = 1'b0;
    latch     = 1'b0;
    case (state)
      WAIT_LOW:   if (!fv_p1) state_nxt = WAIT_FRAME;
      WAIT_FRAME: if (fv_rise) begin
                    clear_acc = 1'b1;
                    track     = 1'b1;
                    state_nxt = ACTIVE;
                  end
      ACTIVE: begin
        track = 1'b1;
        if (fv_fall) state_nxt = LATCH;
      end
      LATCH: begin
        latch     = 1'b1;
        state_nxt = WAIT_FRAME;
      end
      default: state_nxt = WAIT_LOW;
    endcase
  end

  assign accumulate = track & fv_p1 & lv_p1 & in_window;
  assign acc_base   = clear_acc ? '0 : acc;

  // ---- stage p2: window accumulators ----
  always_ff @(posedge clk) begin
    acc <= acc_base;
    if (accumulate) begin
      acc.sum         <= sat_add32(acc_base.sum, pixel_p1);
      acc.pixel_count <= sat_inc24(acc_base.pixel_count, 1'b1);
      acc.sat_count   <= sat_inc24(acc_base.sat_count, pix_ext >= SAT_LVL);
      if (pixel_p1 > acc_base.max_pixel) acc.max_pixel <= pixel_p1;
    end
  end

  // ---- stage p3: frame-end result latch ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res          <= '0;
      frame_count  <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= latch;
      if (latch) begin
        res             <= acc;
        // y holds the completed line count once the frame has ended
        res.short_frame <= (32'(y) < LINES_REQ);
        frame_count     <= frame_count + 8'd1;
      end
    end
  end

  assign sum         = res.sum;
  assign pixel_count = res.pixel_count;
  assign max_pixel   = res.max_pixel;
  assign sat_count   = res.sat_count;
  assign short_frame = res.short_frame;

endmodule

// File: tb/tb_cam_metering.sv
module tb_cam_metering;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fv = 1'b0;
  logic        lv = 1'b0;
  logic [9:0]  pixel_data = '0;
  logic [31:0] sum;
  logic [23:0] pixel_count;
  logic [9:0]  max_pixel;
  logic [23:0] sat_count;
  logic [7:0]  frame_count;
  logic        short_frame;
  logic        result_valid;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  int wide_cnt = 0;
  logic rv_prev = 1'b0;

  always #5 clk = ~clk;

  cam_metering #(
    .PIXEL_W    (10),
    .X_OFFSET   (2),
    .Y_OFFSET   (1),
    .X          (4),
    .Y          (2),
    .SAT_THRESH (1000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pixel_data   (pixel_data),
    .fv           (fv),
    .lv           (lv),
    .sum          (sum),
    .pixel_count  (pixel_count),
    .max_pixel    (max_pixel),
    .sat_count    (sat_count),
    .frame_count  (frame_count),
    .short_frame  (short_frame),
    .result_valid (result_valid)
  );

  // pulse counter and width monitor
  always @(negedge clk) begin
    if (result_valid) begin
      if (rv_prev) wide_cnt++;
      else         rv_cnt++;
    end
    rv_prev = result_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int s, input int c, input int m,
                             input int st, input int sh, input int fc);
    check({tag, "_sum"},   sum, s);
    check({tag, "_count"}, 32'(pixel_count), c);
    check({tag, "_max"},   32'(max_pixel), m);
    check({tag, "_sat"},   32'(sat_count), st);
    check({tag, "_short"}, 32'(short_frame), sh);
    check({tag, "_fc"},    32'(frame_count), fc);
  endtask

  task automatic check_zero(input string tag);
    check_stats(tag, 0, 0, 0, 0, 0, 0);
    check({tag, "_rv"}, 32'(result_valid), 0);
  endtask

  function automatic logic [9:0] pix_val(input int p, input bit ramp);
    int v;
    v = ramp ? p * 200 : 100;
    if (v > 1023) v = 1023;
    return 10'(v);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pixels(input int first, input int last, input bit ramp);
    for (int p = first; p <= last; p++) begin
      lv = 1'b1;
      pixel_data = pix_val(p, ramp);
      @(negedge clk);
    end
  endtask

  task automatic end_line();
    lv = 1'b0;
    pixel_data = '0;
    idle(2);
  endtask

  task automatic frame_end(input bit wait_rv);
    int k;
    fv = 1'b0;
    lv = 1'b0;
    if (wait_rv) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!result_valid && k < 10);
      if (!result_valid) begin
        check("rv_timeout", 0, 1);
      end else begin
        // first edge samples fv low, rv follows two cycles later
        check("rv_latency", k - 1, 2);
        @(negedge clk);
        check("rv_width", 32'(result_valid), 0);
      end
    end
  endtask

  task automatic send_frame(input int nlines, input bit ramp);
    fv = 1'b1;
    lv = 1'b0;
    @(negedge clk);
    for (int l = 0; l < nlines; l++) begin
      send_pixels(0, 7, ramp);
      end_line();
    end
    frame_end(1'b1);
    idle(2);
  endtask

  task automatic spurious_lv();
    lv = 1'b1;
    pixel_data = 10'd1023;
    idle(3);
    lv = 1'b0;
    pixel_data = '0;
    idle(2);
  endtask

  initial begin
    int n;
    int w;
    idle(3);
    check_zero("reset");
    reset_n = 1'b1;
    idle(4);

    // nominal frame: 2 rows x 4 columns of 100
    send_frame(4, 1'b0);
    check_stats("nominal", 800, 8, 100, 0, 0, 1);

    // ramp: columns 2..5 give 400,600,800,1000 per row
    send_frame(4, 1'b1);
    check_stats("ramp", 5600, 8, 1000, 2, 0, 2);

    // short frame: only row 1 of the window seen
    send_frame(2, 1'b0);
    check_stats("short", 400, 4, 100, 0, 1, 3);

    // reset during line 2 of a frame, released with fv still high
    fv = 1'b1;
    @(negedge clk);
    send_pixels(0, 7, 1'b0);
    end_line();
    send_pixels(0, 7, 1'b0);
    end_line();
    send_pixels(0, 2, 1'b0);
    reset_n = 1'b0;
    idle(2);
    check_zero("midreset");
    reset_n = 1'b1;
    send_pixels(3, 7, 1'b0);
    end_line();
    send_pixels(0, 7, 1'b0);
    end_line();
    n = rv_cnt;
    frame_end(1'b0);
    idle(10);
    check("midreset_no_rv", rv_cnt - n, 0);
    check("midreset_fc", 32'(frame_count), 0);
    send_frame(4, 1'b0);
    check_stats("after_reset", 800, 8, 100, 0, 0, 1);

    // lv pulses with fv low must not disturb statistics
    spurious_lv();
    send_frame(4, 1'b0);
    spurious_lv();
    send_frame(4, 1'b0);
    check_stats("spurious", 800, 8, 100, 0, 0, 3);

    // frame counter wrap
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    n = rv_cnt;
    w = wide_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(4, 1'b0);
      if (i == 254) check("wrap_fc255", 32'(frame_count), 255);
    end
    idle(2);
    check("wrap_fc0", 32'(frame_count), 0);
    check("wrap_pulses", rv_cnt - n, 256);
    check("wrap_wide", wide_cnt - w, 0);
    check_stats("wrap", 800, 8, 100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_metering.md
Name: cam_metering

Overview:
- Per-frame exposure statistics block on the camera pixel path.
- Consumes fv, lv and pixel data from the byte-to-pixel converter, in parallel with the debayer. Runs on the pixel clock.
- Over a programmable rectangular window it accumulates:
  - pixel sum
  - pixel count
  - maximum pixel value
  - saturated-pixel count
- Results are latched at frame end for the SPI register interface and auto-exposure firmware.

Parameters:
- PIXEL_W, 10, width of incoming pixel data (RAW10).
- X_OFFSET, 0, first window column (0-based, counted in valid pixels within a line).
- Y_OFFSET, 0, first window row (0-based, counted in lines within a frame).
- X, 1288, window width in pixels.
- Y, 768, window height in lines.
- SAT_THRESH, 1000, pixel value >= this counts as saturated.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- pixel_data  in  PIXEL_W  pixel value, qualified by fv & lv.
- fv  in  1  frame valid.
- lv  in  1  line valid.
- sum  out  32  latched window pixel sum.
- pixel_count  out  24  latched number of window pixels accumulated.
- max_pixel  out  PIXEL_W  latched maximum window pixel.
- sat_count  out  24  latched count of window pixels >= SAT_THRESH.
- frame_count  out  8  completed frames measured; wraps 255->0.
- short_frame  out  1  latched: last frame ended before the window's last line completed.
- result_valid  out  1  one-cycle pulse when the latched outputs update.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - FSM enters WAIT_LOW.
- Input registration: fv, lv and pixel_data are registered once. All edge detection uses the registered and the one-cycle-delayed copies.
- FSM states:
  - WAIT_LOW: wait for registered fv == 0. This guarantees a frame that is in progress at reset release is discarded. Then go to WAIT_FRAME.
  - WAIT_FRAME: on fv rising, clear x, y and the working accumulators, then go to ACTIVE. A pixel present in that same cycle (fv & lv) is processed as pixel (x=0, y=0).
  - ACTIVE:
    - Each cycle with fv & lv: the pixel is at (x, y), then x increments.
    - On lv falling: y increments and x clears.
    - On fv falling: go to LATCH. If lv falls in the same cycle as fv, the line still counts toward the short_frame check.
  - LATCH, one cycle:
    - Copy the working accumulators to the outputs and assert result_valid.
    - Increment frame_count.
    - Set short_frame = (lines completed < Y_OFFSET + Y).
    - Go to WAIT_FRAME.
- Window test: in_window = (x >= X_OFFSET) && (x < X_OFFSET + X) && (y >= Y_OFFSET) && (y < Y_OFFSET + Y).
- Per in-window pixel:
  - sum += pixel, saturating at 0xFFFFFFFF.
  - pixel_count += 1, saturating at 0xFFFFFF.
  - max_pixel = max(max_pixel, pixel).
  - sat_count += (pixel >= SAT_THRESH), saturating at 0xFFFFFF.
- Counter widths: x and y counters are 16 bits and saturate at 0xFFFF; pixels beyond that are out of window.
- lv activity while fv is low is ignored in every state.
- Latency: result_valid asserts 2 cycles after the raw fv falling edge (1 register + LATCH). Outputs stay stable between pulses.
- A new fv rising edge arriving during LATCH is not possible for a compliant source. If it happens, that frame is skipped: WAIT_FRAME waits for the next rising edge.

Decomposition:
- Shared package cam_pkg holds:
  - PIXEL_W
  - a cam_stats_t struct (sum, pixel_count, max_pixel, sat_count, short_frame)
  - the FSM state enum
- One natural sub-module, pixel_window_counter. It takes registered fv/lv, produces x, y, in_window, fv_rise, fv_fall and lv_fall, and is reusable by the debayer crop logic.

Test Plan:
1. Nominal frame.
   - Setup: X_OFFSET=2, Y_OFFSET=1, X=4, Y=2; frame of 4 lines × 8 pixels, all pixels = 100.
   - Expect: sum=800, pixel_count=8, max_pixel=100, sat_count=0, short_frame=0, frame_count=1; one result_valid pulse exactly 2 cycles after fv falls.
2. Ramp and saturation.
   - Setup: same window, SAT_THRESH=1000, pixel = x*200 (x=0..7, clipped to 1023).
   - Expect (window columns 2..5, two rows): sum=2*(400+600+800+1000)=5600, max_pixel=1000, sat_count=2.
3. Short frame.
   - Setup: fv falls after 2 lines.
   - Expect: pixel_count=4 (row 1 only), short_frame=1, result_valid pulses.
4. Reset mid-frame.
   - Setup: assert reset_n low during line 2, release while fv is still high.
   - Expect: all outputs 0, no result_valid for that frame; the next full frame reproduces the scenario 1 results with frame_count=1.
5. Spurious lv outside frame.
   - Setup: pulse lv with pixel 1023 while fv is low, both before and between frames.
   - Expect: statistics identical to scenario 1.
6. Wrap.
   - Setup: 256 back-to-back frames.
   - Expect: frame_count reads 0 after the 256th result_valid, and each pulse is exactly one cycle wide.
